sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
Shares one asynchronous 8-bit SRAM chip between a read-only video scan port and a read/write CPU port. It sequences the chip strobes (CE1n/CE2/OEn/WEn) with registered, glitch-free timing and a programmable strobe width. It sits between the video/CPU logic and the behavioural SRAM model (board-level chip equivalent), replacing direct CPU wiring to the chip.

Parameters:
DATA_WIDTH, 8, SRAM data width
ADDR_WIDTH, 10, SRAM address width
WAIT_CYCLES, 2, cycles OEn/WEn held low per access; legal 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
RESETn  in  1  asynchronous active-low reset
vid_req  in  1  video read request, held high until vid_ack
vid_addr  in  ADDR_WIDTH  video read address, stable while vid_req high
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  DATA_WIDTH  last video read data, held until next video read
cpu_req  in  1  CPU request, held high until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req high
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_din  in  DATA_WIDTH  CPU write data
cpu_ack  out  1  one-cycle pulse, access complete
cpu_dout  out  DATA_WIDTH  last CPU read data, held until next CPU read
ADDR  out  ADDR_WIDTH  SRAM address
CE1n  out  1  SRAM chip enable, active low
CE2  out  1  SRAM chip enable, active high; always equals ~CE1n
OEn  out  1  SRAM output enable, active low
WEn  out  1  SRAM write enable, active low
DATA_OUT  out  DATA_WIDTH  write data to SRAM
DATA_OE  out  1  1 = drive DATA_OUT onto SRAM data bus
DATA_IN  in  DATA_WIDTH  read data from SRAM bus

Behaviour:
- All outputs registered. Reset values: CE1n=1, CE2=0, OEn=1, WEn=1, DATA_OE=0, ADDR=0, DATA_OUT=0, acks=0, vid_data=0, cpu_dout=0, state=IDLE.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE: chip deselected, strobes high, DATA_OE=0. If any req high, latch grant, address, we, write data; go SETUP. No req: stay.
- SETUP (1 cycle): ADDR valid, CE1n=0/CE2=1, OEn=WEn=1; for writes DATA_OE=1, DATA_OUT valid.
- STROBE (WAIT_CYCLES cycles, counter 4 bits): read: OEn=0; write: WEn=0. Never both low.
- HOLD (1 cycle): strobes high, CE still asserted, write data still driven; granted ack=1. Read data sampled from DATA_IN at edge STROBE->HOLD into vid_data or cpu_dout.
- Latency: req seen in IDLE at cycle t -> ack during cycle t+2+WAIT_CYCLES (t+4 default). Minimum access period WAIT_CYCLES+3.
- ADDR/DATA_OUT change only on IDLE->SETUP edge; never while a strobe is low.
- Handshake: requester drops req on the edge where ack=1; IDLE samples after. Req held high = back-to-back access, one IDLE cycle between.
- Req dropped mid-access: protocol violation; access still completes and ack still pulses.
- Arbitration (default): fixed priority, video over CPU on simultaneous requests; grant changes only in IDLE.
- Async reset mid-access: all outputs to reset values immediately; no ack for aborted access; SRAM write content undefined.

Optional Feature:
SRAM_ARB_ROUNDROBIN_EN: defined -> 1-bit last-grant register (reset = CPU); tie goes to port not granted last, so video wins first tie then alternates. Undefined -> fixed video priority, no last-grant register.

Test Plan:
- Reset released, no reqs 20 cycles -> CE1n=1, CE2=0, OEn=1, WEn=1, DATA_OE=0 throughout, no ack.
- CPU write addr 0x155 data 0xA5, WAIT_CYCLES=2 -> ADDR=0x155, DATA_OUT=0xA5, DATA_OE=1 from SETUP through HOLD, WEn low exactly 2 cycles, OEn high, cpu_ack single pulse 4 cycles after req sampled.
- Video read 0x155 after above, SRAM model attached -> OEn low 2 cycles, WEn high, vid_data=0xA5 with vid_ack, cpu_dout unchanged.
- vid_req and cpu_req held high together 8 accesses -> default: all 8 video, cpu_ack never; with SRAM_ARB_ROUNDROBIN_EN: order V,C,V,C,V,C,V,C.
- RESETn low during 2nd STROBE cycle of a CPU write -> same-instant return to reset outputs, no cpu_ack after release, next access normal.
- cpu_req read held high 3 accesses, WAIT_CYCLES=4 -> cpu_ack pulses every 7 cycles, exactly one IDLE cycle between HOLD and next SETUP.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Two-port (video read / CPU read-write) arbiter for one asynchronous SRAM with registered strobes.
// Optional SRAM_ARB_ROUNDROBIN_EN: alternate grants on ties instead of fixed video priority.
module sram_access_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  RESETn,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_ack,
   output logic [DATA_WIDTH-1:0] vid_data,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_din,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_dout,
   output logic [ADDR_WIDTH-1:0] ADDR,
   output logic                  CE1n,
   output logic                  CE2,
   output logic                  OEn,
   output logic                  WEn,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DATA_OE,
   input  logic [DATA_WIDTH-1:0] DATA_IN
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  gnt_cpu_q, gnt_cpu_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ce1n_q, ce1n_d;
   logic                  ce2_q, ce2_d;
   logic                  oen_q, oen_d;
   logic                  wen_q, wen_d;
   logic                  data_oe_q, data_oe_d;
   logic                  vid_ack_q, vid_ack_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
   logic [DATA_WIDTH-1:0] cpu_dout_q, cpu_dout_d;
   logic                  pick_cpu;

`ifdef SRAM_ARB_ROUNDROBIN_EN
   logic last_cpu_q, last_cpu_d;

   // On a tie the port not granted last wins; reset value favours video first.
   always_comb begin
      pick_cpu   = cpu_req & (~vid_req | ~last_cpu_q);
      last_cpu_d = last_cpu_q;
      if (state_q == IDLE && (vid_req || cpu_req)) last_cpu_d = pick_cpu;
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) last_cpu_q <= 1'b1;
      else         last_cpu_q <= last_cpu_d;
   end
`else
   always_comb pick_cpu = cpu_req & ~vid_req;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_cpu_d  = gnt_cpu_q;
      we_d       = we_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      ce1n_d     = ce1n_q;
      ce2_d      = ce2_q;
      oen_d      = oen_q;
      wen_d      = wen_q;
      data_oe_d  = data_oe_q;
      vid_ack_d  = 1'b0;
      cpu_ack_d  = 1'b0;
      vid_data_d = vid_data_q;
      cpu_dout_d = cpu_dout_q;
      case (state_q)
         IDLE: begin
            if (vid_req || cpu_req) begin
               state_d   = SETUP;
               gnt_cpu_d = pick_cpu;
               we_d      = pick_cpu & cpu_we;
               addr_d    = pick_cpu ? cpu_addr : vid_addr;
               if (pick_cpu && cpu_we) dout_d = cpu_din;
               ce1n_d    = 1'b0;
               ce2_d     = 1'b1;
               data_oe_d = pick_cpu & cpu_we;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = STROBE_LAST;
            oen_d   = we_q;
            wen_d   = ~we_q;
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d   = HOLD;
               oen_d     = 1'b1;
               wen_d     = 1'b1;
               vid_ack_d = ~gnt_cpu_q;
               cpu_ack_d = gnt_cpu_q;
               // Read data is captured while OEn is still low on the chip.
               if (!we_q) begin
                  if (gnt_cpu_q) cpu_dout_d = DATA_IN;
                  else           vid_data_d = DATA_IN;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            state_d   = IDLE;
            ce1n_d    = 1'b1;
            ce2_d     = 1'b0;
            data_oe_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gnt_cpu_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         dout_q     <= '0;
         ce1n_q     <= 1'b1;
         ce2_q      <= 1'b0;
         oen_q      <= 1'b1;
         wen_q      <= 1'b1;
         data_oe_q  <= 1'b0;
         vid_ack_q  <= 1'b0;
         cpu_ack_q  <= 1'b0;
         vid_data_q <= '0;
         cpu_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_cpu_q  <= gnt_cpu_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         ce1n_q     <= ce1n_d;
         ce2_q      <= ce2_d;
         oen_q      <= oen_d;
         wen_q      <= wen_d;
         data_oe_q  <= data_oe_d;
         vid_ack_q  <= vid_ack_d;
         cpu_ack_q  <= cpu_ack_d;
         vid_data_q <= vid_data_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

   assign ADDR     = addr_q;
   assign DATA_OUT = dout_q;
   assign CE1n     = ce1n_q;
   assign CE2      = ce2_q;
   assign OEn      = oen_q;
   assign WEn      = wen_q;
   assign DATA_OE  = data_oe_q;
   assign vid_ack  = vid_ack_q;
   assign cpu_ack  = cpu_ack_q;
   assign vid_data = vid_data_q;
   assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: default-timing instance with an SRAM model,
// plus a WAIT_CYCLES=4 instance for back-to-back period checks.
module tb_sram_access_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       RESETn;
   logic       vid_req, vid_ack, cpu_req, cpu_we, cpu_ack;
   logic [9:0] vid_addr, cpu_addr, ADDR;
   logic [7:0] vid_data, cpu_din, cpu_dout, DATA_OUT, DATA_IN;
   logic       CE1n, CE2, OEn, WEn, DATA_OE;

   logic       vid4_req, vid4_ack, cpu4_req, cpu4_we, cpu4_ack;
   logic [9:0] vid4_addr, cpu4_addr, ADDR4;
   logic [7:0] vid4_data, cpu4_din, cpu4_dout, DATA_OUT4;
   logic [7:0] DATA_IN4;
   logic       CE1n4, CE24, OEn4, WEn4, DATA_OE4;

   sram_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .RESETn(RESETn),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .ADDR(ADDR), .CE1n(CE1n), .CE2(CE2), .OEn(OEn), .WEn(WEn),
      .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN));

   sram_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .WAIT_CYCLES(4)) dut4 (
      .clk(clk), .RESETn(RESETn),
      .vid_req(vid4_req), .vid_addr(vid4_addr), .vid_ack(vid4_ack), .vid_data(vid4_data),
      .cpu_req(cpu4_req), .cpu_we(cpu4_we), .cpu_addr(cpu4_addr), .cpu_din(cpu4_din),
      .cpu_ack(cpu4_ack), .cpu_dout(cpu4_dout),
      .ADDR(ADDR4), .CE1n(CE1n4), .CE2(CE24), .OEn(OEn4), .WEn(WEn4),
      .DATA_OUT(DATA_OUT4), .DATA_OE(DATA_OE4), .DATA_IN(DATA_IN4));

   // Behavioural SRAM: writes land while WEn is low, reads drive while OEn is low.
   logic [7:0] mem [0:1023];
   always @(posedge clk)
      if (!CE1n && CE2 && !WEn && DATA_OE) mem[ADDR] <= DATA_OUT;
   assign DATA_IN  = (!CE1n && CE2 && !OEn) ? mem[ADDR] : 8'hEE;
   assign DATA_IN4 = 8'h5A;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic       is_cpu;
      logic       chk;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t sb4[$];
   exp_t e, e4;

   always @(negedge clk) begin
      if (RESETn && (vid_ack || cpu_ack)) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_ack vid_ack=%0b cpu_ack=%0b expected no ack", vid_ack, cpu_ack);
         end else begin
            e = sb.pop_front();
            if ((vid_ack && cpu_ack) || (cpu_ack !== e.is_cpu)) begin
               fails++;
               $display("FAIL sb_port got vid_ack=%0b cpu_ack=%0b expected cpu=%0b", vid_ack, cpu_ack, e.is_cpu);
            end else if (e.chk && ((e.is_cpu ? cpu_dout : vid_data) !== e.data)) begin
               fails++;
               $display("FAIL sb_data got %h expected %h", e.is_cpu ? cpu_dout : vid_data, e.data);
            end
         end
      end
      if (RESETn && (vid4_ack || cpu4_ack)) begin
         tests++;
         if (sb4.size() == 0) begin
            fails++;
            $display("FAIL sb4_unexpected_ack vid_ack=%0b cpu_ack=%0b expected no ack", vid4_ack, cpu4_ack);
         end else begin
            e4 = sb4.pop_front();
            if (vid4_ack || !cpu4_ack || (e4.chk && cpu4_dout !== e4.data)) begin
               fails++;
               $display("FAIL sb4_ack got vid=%0b cpu=%0b dout=%h expected cpu ack dout=%h",
                        vid4_ack, cpu4_ack, cpu4_dout, e4.data);
            end
         end
      end
   end

   task automatic test_reset();
      RESETn = 1'b0;
      vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      vid4_req = 0; vid4_addr = '0; cpu4_req = 0; cpu4_we = 0; cpu4_addr = '0; cpu4_din = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({CE1n, CE2, OEn, WEn, DATA_OE, vid_ack, cpu_ack, ADDR, DATA_OUT, vid_data, cpu_dout} !==
          {7'b1011000, 10'h0, 8'h0, 8'h0, 8'h0}) begin
         fails++;
         $display("FAIL reset_values got ctl=%b addr=%h dout=%h vd=%h cd=%h expected ctl=1011000 all zero",
                  {CE1n, CE2, OEn, WEn, DATA_OE, vid_ack, cpu_ack}, ADDR, DATA_OUT, vid_data, cpu_dout);
      end
      RESETn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         tests++;
         if ({CE1n, CE2, OEn, WEn, DATA_OE, vid_ack, cpu_ack} !== 7'b1011000) begin
            fails++;
            $display("FAIL idle_strobes cycle %0d got %b expected 1011000", k,
                     {CE1n, CE2, OEn, WEn, DATA_OE, vid_ack, cpu_ack});
         end
      end
   endtask

   task automatic test_cpu_write(input logic [9:0] a, input logic [7:0] d);
      int wen_lo = 0, oen_lo = 0, oe_cyc = 0, bad = 0, ack_k = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_din = d;
      sb.push_back('{is_cpu: 1'b1, chk: 1'b0, data: 8'h00});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (!WEn) wen_lo++;
         if (!OEn) oen_lo++;
         if (!WEn && !OEn) bad++;
         if (DATA_OE) begin
            oe_cyc++;
            if (DATA_OUT !== d || ADDR !== a || CE1n || !CE2) bad++;
         end
         if (cpu_ack) begin
            ack_k = (ack_k == 0) ? k : 99;
            cpu_req = 0;
         end
      end
      tests++;
      if (ack_k != 4 || wen_lo != 2 || oen_lo != 0 || oe_cyc != 4 || bad != 0) begin
         fails++;
         $display("FAIL cpu_write got ack_cycle=%0d wen_lo=%0d oen_lo=%0d oe_cycles=%0d bad=%0d expected 4 2 0 4 0",
                  ack_k, wen_lo, oen_lo, oe_cyc, bad);
      end
   endtask

   task automatic test_video_read(input logic [9:0] a, input logic [7:0] d);
      int wen_lo = 0, oen_lo = 0, bad = 0, ack_k = 0;
      logic [7:0] cpu_before;
      cpu_before = cpu_dout;
      vid_req = 1; vid_addr = a;
      sb.push_back('{is_cpu: 1'b0, chk: 1'b1, data: d});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (!WEn) wen_lo++;
         if (!OEn) begin
            oen_lo++;
            if (ADDR !== a || CE1n) bad++;
         end
         if (DATA_OE) bad++;
         if (vid_ack) begin
            ack_k = (ack_k == 0) ? k : 99;
            vid_req = 0;
         end
      end
      tests++;
      if (ack_k != 4 || wen_lo != 0 || oen_lo != 2 || bad != 0 || vid_data !== d || cpu_dout !== cpu_before) begin
         fails++;
         $display("FAIL video_read got ack_cycle=%0d wen_lo=%0d oen_lo=%0d bad=%0d vid_data=%h cpu_dout=%h expected 4 0 2 0 %h %h",
                  ack_k, wen_lo, oen_lo, bad, vid_data, cpu_dout, d, cpu_before);
      end
   endtask

   task automatic test_arbitration();
      int vcnt = 0, ccnt = 0;
      vid_addr = 10'h155; cpu_addr = 10'h0AA; cpu_we = 0;
      for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_ROUNDROBIN_EN
         if (i % 2 == 1) sb.push_back('{is_cpu: 1'b1, chk: 1'b1, data: 8'h3C});
         else            sb.push_back('{is_cpu: 1'b0, chk: 1'b1, data: 8'hA5});
`else
         sb.push_back('{is_cpu: 1'b0, chk: 1'b1, data: 8'hA5});
`endif
      end
      vid_req = 1; cpu_req = 1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (vid_ack) vcnt++;
         if (cpu_ack) ccnt++;
         if (vcnt + ccnt == 8) begin
            vid_req = 0; cpu_req = 0;
            break;
         end
      end
      vid_req = 0; cpu_req = 0;
      repeat (4) @(negedge clk);
      tests++;
`ifdef SRAM_ARB_ROUNDROBIN_EN
      if (vcnt != 4 || ccnt != 4) begin
`else
      if (vcnt != 8 || ccnt != 0) begin
`endif
         fails++;
         $display("FAIL arbitration got video=%0d cpu=%0d acks", vcnt, ccnt);
      end
   endtask

   task automatic test_reset_mid_access();
      int stray = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 10'h200; cpu_din = 8'h77;
      sb.push_back('{is_cpu: 1'b1, chk: 1'b0, data: 8'h00});
      repeat (3) @(negedge clk);
      tests++;
      if (WEn !== 1'b0) begin
         fails++;
         $display("FAIL mid_strobe got WEn=%b expected 0", WEn);
      end
      RESETn = 1'b0;
      #1;
      tests++;
      if ({CE1n, CE2, OEn, WEn, DATA_OE, cpu_ack, ADDR, DATA_OUT} !== {6'b101100, 10'h0, 8'h0}) begin
         fails++;
         $display("FAIL async_reset got ctl=%b addr=%h dout=%h expected 101100 0 0",
                  {CE1n, CE2, OEn, WEn, DATA_OE, cpu_ack}, ADDR, DATA_OUT);
      end
      sb.delete();
      cpu_req = 0;
      @(negedge clk);
      RESETn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (cpu_ack || !CE1n) stray++;
      end
      tests++;
      if (stray != 0) begin
         fails++;
         $display("FAIL reset_no_ack got %0d active cycles expected 0", stray);
      end
      test_cpu_write(10'h200, 8'h77);
      test_video_read(10'h200, 8'h77);
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      logic exp_ack, exp_ce1n;
      cpu4_req = 1; cpu4_we = 0; cpu4_addr = 10'h3FF;
      repeat (3) sb4.push_back('{is_cpu: 1'b1, chk: 1'b1, data: 8'h5A});
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         exp_ack  = (k == 6) || (k == 13) || (k == 20);
         exp_ce1n = (k == 7) || (k == 14) || (k >= 21);
         tests++;
         if (cpu4_ack !== exp_ack || CE1n4 !== exp_ce1n) begin
            fails++;
            $display("FAIL b2b cycle %0d got ack=%b ce1n=%b expected ack=%b ce1n=%b",
                     k, cpu4_ack, CE1n4, exp_ack, exp_ce1n);
         end
         if (cpu4_ack) begin
            acks++;
            if (acks == 3) cpu4_req = 0;
         end
      end
      cpu4_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset();
      test_cpu_write(10'h155, 8'hA5);
      test_video_read(10'h155, 8'hA5);
      test_cpu_write(10'h0AA, 8'h3C);
      test_arbitration();
      test_reset_mid_access();
      test_back_to_back();
      repeat (2) @(negedge clk);
      tests++;
      if (sb.size() != 0 || sb4.size() != 0) begin
         fails++;
         $display("FAIL sb_drain got %0d/%0d pending expected 0/0", sb.size(), sb4.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
